// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with writable imem and register-file control decode

module if_stage #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               valid,
  output logic [3:0]         read1,
  output logic [3:0]         read2,
  output logic [3:0]         write,
  output logic [INSTR_W-1:0] data,
  output logic               readEnable,
  output logic               writeEnable,
  output logic               halted,
  output logic               illegal
);

  localparam int DEPTH = 1 << PC_W;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_READ = 4'h1,
    OP_LDI  = 4'h2,
    OP_JMP  = 4'h3,
    OP_HALT = 4'hF
  } op_e;

  logic [INSTR_W-1:0] imem [DEPTH];

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [3:0]         read1_q, read1_d;
  logic [3:0]         read2_q, read2_d;
  logic [3:0]         write_q, write_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic               re_q, re_d;
  logic               we_q, we_d;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;

  logic [INSTR_W-1:0] fetch_w;
  op_e                op;
  logic               issue;

  // Asynchronous read: the word at pc is decoded in the same cycle it is addressed.
  assign fetch_w = imem[pc_q];
  assign op      = op_e'(fetch_w[15:12]);
  assign issue   = !stall && !halted_q;

  // Next-state decode: strobes default low so a held or halted cycle never repeats a write.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    read1_d   = read1_q;
    read2_d   = read2_q;
    write_d   = write_q;
    data_d    = data_q;
    halted_d  = halted_q;
    valid_d   = 1'b0;
    re_d      = 1'b0;
    we_d      = 1'b0;
    illegal_d = 1'b0;
    if (issue) begin
      instr_d = fetch_w;
      valid_d = 1'b1;
      read1_d = fetch_w[7:4];
      read2_d = fetch_w[3:0];
      write_d = fetch_w[11:8];
      data_d  = '0;
      pc_d    = pc_q + 1'b1;
      case (op)
        OP_NOP:  ;
        OP_READ: re_d = 1'b1;
        OP_LDI: begin
          we_d   = 1'b1;
          data_d = INSTR_W'(fetch_w[7:0]);
        end
        OP_JMP:  pc_d = PC_W'(fetch_w[7:0]);
        OP_HALT: halted_d = 1'b1;
        default: illegal_d = 1'b1;
      endcase
    end
  end

  // Pipeline output registers; reset clears everything except imem.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      read1_q   <= '0;
      read2_q   <= '0;
      write_q   <= '0;
      data_q    <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      read1_q   <= read1_d;
      read2_q   <= read2_d;
      write_q   <= write_d;
      data_q    <= data_d;
      re_q      <= re_d;
      we_q      <= we_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Program port: writes land in every state; the fetch on the same edge sees the old word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      imem[prog_addr] <= prog_data;
    end
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign valid       = valid_q;
  assign read1       = read1_q;
  assign read2       = read2_q;
  assign write       = write_q;
  assign data        = data_q;
  assign readEnable  = re_q;
  assign writeEnable = we_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage against a behavioural model

module tb_if_stage;

  localparam int PC_W  = 8;
  localparam int DEPTH = 1 << PC_W;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            stall = 1'b0;
  logic            prog_we = 1'b0;
  logic [PC_W-1:0] prog_addr = '0;
  logic [15:0]     prog_data = '0;
  logic [PC_W-1:0] pc;
  logic [15:0]     instr;
  logic            valid;
  logic [3:0]      read1, read2, write;
  logic [15:0]     data;
  logic            readEnable, writeEnable, halted, illegal;

  if_stage #(.PC_W(PC_W), .INSTR_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .pc(pc), .instr(instr), .valid(valid),
    .read1(read1), .read2(read2), .write(write), .data(data),
    .readEnable(readEnable), .writeEnable(writeEnable),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: memory image, program counter and the expected output fields.
  logic [15:0] m_mem [DEPTH];
  int          m_pc;
  bit          m_halted;
  logic [15:0] e_instr, e_data;
  logic [3:0]  e_r1, e_r2, e_wr;
  bit          e_valid, e_re, e_we, e_ill;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = 0; m_halted = 0;
    e_instr = '0; e_data = '0; e_r1 = '0; e_r2 = '0; e_wr = '0;
    e_valid = 0; e_re = 0; e_we = 0; e_ill = 0;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".pc"},      32'(pc),          32'(m_pc));
    check_eq({tag, ".instr"},   32'(instr),       32'(e_instr));
    check_eq({tag, ".valid"},   32'(valid),       32'(e_valid));
    check_eq({tag, ".read1"},   32'(read1),       32'(e_r1));
    check_eq({tag, ".read2"},   32'(read2),       32'(e_r2));
    check_eq({tag, ".write"},   32'(write),       32'(e_wr));
    check_eq({tag, ".data"},    32'(data),        32'(e_data));
    check_eq({tag, ".re"},      32'(readEnable),  32'(e_re));
    check_eq({tag, ".we"},      32'(writeEnable), 32'(e_we));
    check_eq({tag, ".halted"},  32'(halted),      32'(m_halted));
    check_eq({tag, ".illegal"}, 32'(illegal),     32'(e_ill));
    check_eq({tag, ".re_and_we"}, 32'(readEnable && writeEnable), 32'(0));
  endtask

  // One clock: drive inputs, advance the model by the instruction-set rules, compare after the edge.
  task automatic step(input bit st, input bit we, input int addr, input logic [15:0] d, input string tag);
    logic [15:0] w;
    logic [3:0]  op;
    stall = st; prog_we = we; prog_addr = PC_W'(addr); prog_data = d;
    @(posedge clk);
    if (!reset) begin
      m_reset();
    end else if (!st && !m_halted) begin
      w  = m_mem[m_pc];
      op = w[15:12];
      e_instr = w; e_valid = 1;
      e_r1 = w[7:4]; e_r2 = w[3:0]; e_wr = w[11:8];
      e_data = (op == 4'h2) ? {8'h00, w[7:0]} : 16'h0000;
      e_re = (op == 4'h1);
      e_we = (op == 4'h2);
      e_ill = !(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'hF});
      if (op == 4'hF) m_halted = 1;
      m_pc = (op == 4'h3) ? int'(w[7:0]) % DEPTH : (m_pc + 1) % DEPTH;
    end else begin
      e_valid = 0; e_re = 0; e_we = 0; e_ill = 0;
    end
    if (we) m_mem[addr] = d;
    #1;
    compare_all(tag);
    prog_we = 1'b0;
  endtask

  task automatic load(input int addr, input logic [15:0] d);
    step(1'b1, 1'b1, addr, d, "load");
  endtask

  task automatic clear_mem();
    for (int a = 0; a < DEPTH; a++) load(a, 16'h0000);
  endtask

  task automatic async_reset_check(input string tag);
    reset = 1'b0;
    #1;
    m_reset();
    compare_all(tag);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2: w[15:12] = 4'h1;
      3, 4, 5: w[15:12] = 4'h2;
      6:       w[15:12] = 4'h3;
      7:       w[15:12] = 4'h0;
      8:       w[15:12] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h2;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    m_reset();
    #2;
    compare_all("reset_initial");

    // Program: LDI, READ, HALT.
    clear_mem();
    load(0, 16'h2A05); load(1, 16'h1034); load(2, 16'hF000);
    reset = 1'b1;
    step(0, 0, 0, 0, "p1_e1");
    check_eq("p1_e1_we_lit", 32'(writeEnable), 32'(1));
    check_eq("p1_e1_data_lit", 32'(data), 32'h0005);
    step(0, 0, 0, 0, "p1_e2");
    check_eq("p1_e2_read1_lit", 32'(read1), 32'(3));
    step(0, 0, 0, 0, "p1_e3");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, "p1_halted");
    check_eq("p1_pc_frozen_lit", 32'(pc), 32'(3));
    // Writes while halted are still accepted.
    step(0, 1, 40, 16'h2B09, "p1_halt_write");

    // Jump with no bubble.
    async_reset_check("p2_reset");
    load(0, 16'h3010); load(16, 16'h2107);
    reset = 1'b1;
    step(0, 0, 0, 0, "p2_jmp");
    check_eq("p2_pc_lit", 32'(pc), 32'(16));
    step(0, 0, 0, 0, "p2_ldi");
    check_eq("p2_pc17_lit", 32'(pc), 32'(17));

    // Stall after an LDI.
    async_reset_check("p3_reset");
    load(0, 16'h2A05); load(1, 16'h1034);
    reset = 1'b1;
    step(0, 0, 0, 0, "p3_ldi");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "p3_stall");
    check_eq("p3_write_held_lit", 32'(write), 32'hA);
    step(0, 0, 0, 0, "p3_resume");
    check_eq("p3_re_lit", 32'(readEnable), 32'(1));

    // 256 NOPs: pc wraps to 0.
    async_reset_check("p4_reset");
    clear_mem();
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, "p4_nop");
    check_eq("p4_pc_wrap_lit", 32'(pc), 32'(0));

    // Undefined opcode pulse.
    async_reset_check("p5_reset");
    load(0, 16'h7123);
    reset = 1'b1;
    step(0, 0, 0, 0, "p5_ill");
    check_eq("p5_ill_lit", 32'(illegal), 32'(1));
    step(0, 0, 0, 0, "p5_ill_gone");

    // Asynchronous reset mid-program at pc=5; memory survives.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "p6_run");
    check_eq("p6_pc5_lit", 32'(pc), 32'(5));
    async_reset_check("p6_async");
    step(0, 0, 0, 0, "p6_in_reset");
    reset = 1'b1;
    step(0, 0, 0, 0, "p6_first");
    check_eq("p6_first_instr_lit", 32'(instr), 32'h7123);

    // Randomized program, stall, writes (some to the current pc) and resets.
    for (int a = 0; a < DEPTH; a++) load(a, rand_word());
    for (int i = 0; i < 3000; i++) begin
      int  addr;
      bit  we;
      addr = ($urandom_range(0, 3) == 0) ? m_pc : int'($urandom_range(0, DEPTH - 1));
      we   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) reset = 1'b0;
      else if (!reset) reset = 1'b1;
      step($urandom_range(0, 9) < 3, we, addr, rand_word(), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the fetch/decode register file.
- Holds a program counter and a writable instruction memory, and fetches one 16-bit instruction per cycle.
- Decodes each instruction into the register-file control fields: read1, read2, write, data, readEnable and writeEnable.
- Handles stall, jump and halt, and guarantees readEnable and writeEnable are never both 1.

Parameters:
- PC_W, 8, program-counter width; instruction memory depth is 2**PC_W words.
- INSTR_W, 16, instruction width; fixed at 16, only the format below is supported.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  downstream hold request; the stage freezes while it is 1.
- prog_we  in  1  instruction-memory write enable.
- prog_addr  in  PC_W  instruction-memory write address.
- prog_data  in  16  instruction-memory write data.
- pc  out  PC_W  address of the instruction currently being fetched.
- instr  out  16  registered copy of the last issued instruction.
- valid  out  1  outputs carry a newly issued instruction this cycle.
- read1  out  4  source register 1 index.
- read2  out  4  source register 2 index.
- write  out  4  destination register index.
- data  out  16  write data (zero-extended immediate).
- readEnable  out  1  register-file read strobe.
- writeEnable  out  1  register-file write strobe.
- halted  out  1  set once HALT has issued.
- illegal  out  1  one-cycle pulse when an undefined opcode issues.

Behaviour:
- Instruction format: op = instr[15:12], rd = instr[11:8], rs1 = instr[7:4], rs2 = instr[3:0], imm8 = instr[7:0].
- Opcode 0x0, NOP: both enables 0.
- Opcode 0x1, READ: readEnable=1, read1=rs1, read2=rs2, writeEnable=0.
- Opcode 0x2, LDI: writeEnable=1, write=rd, data={8'h00, imm8}, readEnable=0.
- Opcode 0x3, JMP: next pc = imm8[PC_W-1:0]; both enables 0.
- Opcode 0xF, HALT: halted is set; both enables 0.
- Any other opcode: handled as NOP; illegal=1 for that issue cycle only.
- Memory read is asynchronous, imem[pc]. All outputs are registered, so latency is 1 cycle from pc to decoded outputs.
- Issue condition: issue = !stall && !halted. On an issue edge:
  - all output fields are loaded;
  - valid=1;
  - pc advances to pc+1, or to the JMP target. Jumps take effect with no bubble.
- Fields not driven by the opcode are loaded from the instruction bits regardless, except that data=0 for every op other than LDI.
- stall=1: pc, instr and all index/data fields hold their values. valid, readEnable, writeEnable and illegal are 0 for that cycle, so no write is ever repeated.
- halted=1: pc freezes, valid and both enables stay 0. Only reset clears halted.
- pc wraps from 2**PC_W-1 to 0.
- prog_we writes imem[prog_addr] on the rising edge. Writes are accepted in every state, including while reset is low and while halted.
- A write to the address currently at pc: the issue on that same edge uses the old word (read-before-write).
- Reset low, asynchronous, at any time including mid-stall or mid-halt:
  - pc=0, instr=0, read1=read2=write=0, data=0;
  - valid=readEnable=writeEnable=halted=illegal=0.
  - imem contents are not reset and are preserved.
- After reset deasserts, the first issue occurs on the first rising edge with stall=0 and fetches imem[0].
- readEnable && writeEnable is never 1 in any cycle. Verification asserts this.

Test Plan:
- Load imem[0]=16'h2A05, imem[1]=16'h1034, imem[2]=16'hF000, then release reset with stall=0.
  - Edge 1: writeEnable=1, write=4'hA, data=16'h0005, pc=1.
  - Edge 2: readEnable=1, read1=3, read2=4, pc=2.
  - Edge 3: halted=1, enables 0, pc stays 3 thereafter.
- Load imem[0]=16'h3010 and imem[16]=16'h2107.
  - Edge 1: JMP issues with enables 0 and pc=16.
  - Edge 2: write=1, data=16'h0007, pc=17.
- Assert stall for 3 cycles after the LDI at imem[0]=16'h2A05.
  - pc holds at 1; valid=writeEnable=0 for those 3 cycles; write=4'hA is held.
  - On the first edge with stall=0, imem[1] issues.
- Fill imem with 16'h0000 (NOP) and run 256 issues from pc=0.
  - pc returns to 0 on the 256th issue; both enables stay 0 throughout.
- Issue opcode 16'h7123.
  - illegal=1 for exactly one cycle; enables stay 0; pc increments normally.
- Drop reset low mid-program at pc=5 while halted=0.
  - All outputs clear immediately, without waiting for a clock edge.
  - After reset rises, the first fetch is imem[0], and imem contents are unchanged.
